// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo_sync family: default word width, the
// read-streamer state encoding and a small saturating-increment helper.
package fifo_pkg;

   // Word width shared with fifo_sync; both blocks must agree on it.
   localparam int FIFO_DATA_WIDTH = 32;

   // Default width of burst_len and the remaining-words counter.
   localparam int FIFO_LEN_WIDTH = 16;

   // Read-streamer control states.
   //   ST_IDLE  : waiting for start, no reads issued.
   //   ST_RUN   : issuing reads while words are wanted and the buffer has room.
   //   ST_DRAIN : no new reads; waiting for in-flight and buffered words to leave.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } rd_state_t;

   // 32-bit increment that sticks at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc32(input logic [31:0] value);
      if (value == 32'hFFFF_FFFF) begin
         return value;
      end
      return value + 32'd1;
   endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer between the fifo_sync data port and the output stream.
// entry0 is always the head; push appends behind the current tail, pop shifts
// entry1 forward. A push and a pop in the same cycle keep occupancy unchanged
// and preserve order. Push into a full buffer without a pop, and pop from an
// empty buffer, are ignored (the read-issue logic never requests either).
module fifo_rd_skid
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] dout,
   output logic [1:0]            occ
);

   logic [DATA_WIDTH-1:0] entry0;
   logic [DATA_WIDTH-1:0] entry1;
   logic [1:0]            occ_q;
   logic                  pop_ok;
   logic                  push_ok;

   // Qualify requests against the current occupancy.
   always_comb begin
      pop_ok  = pop && (occ_q != 2'd0);
      push_ok = push && ((occ_q != 2'd2) || pop_ok);
   end

   // Storage and occupancy update; entry0 always holds the oldest word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entry0 <= '0;
         entry1 <= '0;
         occ_q  <= 2'd0;
      end else begin
         case ({push_ok, pop_ok})
            2'b10: begin
               if (occ_q == 2'd0) begin
                  entry0 <= din;
               end else begin
                  entry1 <= din;
               end
               occ_q <= occ_q + 2'd1;
            end
            2'b01: begin
               entry0 <= entry1;
               occ_q  <= occ_q - 2'd1;
            end
            2'b11: begin
               if (occ_q == 2'd1) begin
                  entry0 <= din;
               end else begin
                  entry0 <= entry1;
                  entry1 <= din;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign dout = entry0;
   assign occ  = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side master for fifo_sync. Issues cs/rd_en reads from the FIFO's empty
// flag, captures fifo_data one cycle after each read into a two-entry skid
// buffer, and presents words on a valid/ready stream.
//
// Stream handshake: a word transfers on a rising edge where m_valid and m_ready
// are both high. m_valid never drops and m_data never changes while
// m_valid && !m_ready. m_ready may depend on nothing from this block.
//
// Read issue is combinationally dependent on m_ready so that a full buffer
// being popped can still accept the word from a read issued this cycle; this
// is what sustains one word per cycle through the two-entry buffer.
//
// Optional statistics: define FIFO_RD_STREAM_STATS_EN to add stat_words
// (words popped) and stat_stall (RUN cycles stalled on an empty FIFO).
module fifo_rd_stream
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int LEN_WIDTH  = FIFO_LEN_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  stop,
   input  logic [LEN_WIDTH-1:0]  burst_len,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_cs,
   output logic                  fifo_rd_en,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  busy,
   output logic                  done
`ifdef FIFO_RD_STREAM_STATS_EN
   ,
   output logic [31:0]           stat_words,
   output logic [31:0]           stat_stall
`endif
);

   localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

   rd_state_t             state_q;
   rd_state_t             state_d;
   logic [LEN_WIDTH-1:0]  remaining_q;
   logic                  cont_q;
   logic                  inflight_q;
   logic [1:0]            occ;
   logic                  pop;
   logic                  issue;
   logic                  words_left;
   logic                  has_room;
   logic [2:0]            occ_after;
   logic                  drained;

   // Words still wanted, buffer space after this cycle, and drain completion.
   always_comb begin
      words_left = cont_q || (remaining_q != '0);
      occ_after  = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
      has_room   = (occ_after < 3'd2);
      drained    = !inflight_q && (occ == 2'd0);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode; stop and the final counted issue both end RUN.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (stop) begin
               state_d = ST_DRAIN;
            end else if (issue && !cont_q && (remaining_q == LEN_ONE)) begin
               state_d = ST_DRAIN;
            end else if (!words_left) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (drained) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State-derived outputs: read issue, busy and the completion pulse.
   always_comb begin
      issue      = (state_q == ST_RUN) && !fifo_empty && words_left && !stop && has_room;
      fifo_cs    = issue;
      fifo_rd_en = issue;
      busy       = (state_q != ST_IDLE);
      done       = (state_q == ST_DRAIN) && drained;
   end

   // Burst length latch, continuous flag, and per-issue countdown (never wraps).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         remaining_q <= '0;
         cont_q      <= 1'b0;
      end else if ((state_q == ST_IDLE) && start) begin
         remaining_q <= burst_len;
         cont_q      <= (burst_len == '0);
      end else if (issue && !cont_q && (remaining_q != '0)) begin
         remaining_q <= remaining_q - LEN_ONE;
      end
   end

   // A read issued this cycle returns data next cycle; reset drops it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= issue;
      end
   end

   assign m_valid = (occ != 2'd0);
   assign pop     = m_valid && m_ready;

   fifo_rd_skid #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (inflight_q),
      .din   (fifo_data),
      .pop   (pop),
      .dout  (m_data),
      .occ   (occ)
   );

`ifdef FIFO_RD_STREAM_STATS_EN
   // Saturating transfer statistics, cleared when a new transfer is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_words <= '0;
         stat_stall <= '0;
      end else if ((state_q == ST_IDLE) && start) begin
         stat_words <= '0;
         stat_stall <= '0;
      end else begin
         if (pop) begin
            stat_words <= sat_inc32(stat_words);
         end
         if ((state_q == ST_RUN) && fifo_empty && words_left) begin
            stat_stall <= sat_inc32(stat_stall);
         end
      end
   end
`endif

endmodule
